// File: rtl/mips_pkg.sv
// Shared types and constants for the EX/MEM boundary: control bundle layout,
// default widths and the registered pipeline entry.
package mips_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;

    localparam int unsigned CTRL_W  = 7;
    localparam int unsigned MCTRL_W = 5;

    // EX control bundle: {memRead, memWrite, regWrite, memToReg, branch, branchNe, halt}
    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam int unsigned CTRL_MEMREAD  = 6;
    localparam int unsigned CTRL_MEMWRITE = 5;
    localparam int unsigned CTRL_REGWRITE = 4;
    localparam int unsigned CTRL_MEMTOREG = 3;
    localparam int unsigned CTRL_BRANCH   = 2;
    localparam int unsigned CTRL_BRANCHNE = 1;
    localparam int unsigned CTRL_HALT     = 0;

    // MEM-side control bundle: {memRead, memWrite, regWrite, memToReg, halt}
    typedef logic [MCTRL_W-1:0] mctrl_t;

    localparam int unsigned MCTRL_MEMREAD  = 4;
    localparam int unsigned MCTRL_MEMWRITE = 3;
    localparam int unsigned MCTRL_REGWRITE = 2;
    localparam int unsigned MCTRL_MEMTOREG = 1;
    localparam int unsigned MCTRL_HALT     = 0;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic [REG_AW_DEF-1:0] rd;
        mctrl_t                ctrl;
    } exmem_entry_t;

    // Branches and writes to r0 never reach the register file.
    function automatic mctrl_t to_mem_ctrl(input ctrl_t c, input logic rd_is_zero);
        mctrl_t m;
        m                 = '0;
        m[MCTRL_MEMREAD]  = c[CTRL_MEMREAD];
        m[MCTRL_MEMWRITE] = c[CTRL_MEMWRITE];
        m[MCTRL_REGWRITE] = c[CTRL_REGWRITE] & ~c[CTRL_BRANCH] & ~rd_is_zero;
        m[MCTRL_MEMTOREG] = c[CTRL_MEMTOREG];
        m[MCTRL_HALT]     = c[CTRL_HALT];
        return m;
    endfunction

endpackage

// File: rtl/exmem_skid_buf.sv
// Two-entry valid/ready skid buffer: head drives the output, skid absorbs one beat
// while the consumer stalls. in_ready is registered and never sees out_ready.
module exmem_skid_buf
    import mips_pkg::*;
#(
    parameter type entry_t = exmem_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  entry_t in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output entry_t out_data
);

    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   head_valid_q, head_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   ready_q;
    logic   accept;
    logic   xfer;

    assign accept = in_valid && ready_q;
    assign xfer   = head_valid_q && out_ready;

    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        if (xfer) begin
            if (skid_valid_q) begin
                // ready_q is low here, so no accept can coincide with the refill
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                head_d = in_data;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!head_valid_q) begin
                head_d       = in_data;
                head_valid_d = 1'b1;
            end else begin
                skid_d       = in_data;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = head_valid_q;
    assign out_data  = head_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: skid-buffered handoff to MEM, BEQ/BNE redirect and
// forwarding from the head entry. Define EX_MEM_STATS_EN to add event counters.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [DATA_W-1:0]   alu_Result,
    input  logic                alu_zeroFlag,
    input  logic [DATA_W-1:0]   rtData,
    input  logic [REG_AW-1:0]   rdAddr,
    input  logic [DATA_W-1:0]   branchTarget,
    input  logic [CTRL_W-1:0]   ctrl,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [REG_AW-1:0]   mem_rd,
    output logic [MCTRL_W-1:0]  mem_ctrl,
    output logic                pcRedirect,
    output logic [DATA_W-1:0]   pcTarget,
    output logic                fwdValid,
    output logic [REG_AW-1:0]   fwdAddr,
    output logic [DATA_W-1:0]   fwdData
`ifdef EX_MEM_STATS_EN
    ,
    output logic [31:0]         statAccepted,
    output logic [31:0]         statStallCycles,
    output logic [31:0]         statRedirects
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [REG_AW-1:0] rd;
        mctrl_t            ctrl;
    } entry_t;

    entry_t            in_entry;
    entry_t            head;
    logic              buf_in_ready;
    logic              head_valid;
    logic              accept;
    logic              taken;
    logic              halted_q;
    logic              redirect_q;
    logic [DATA_W-1:0] pc_target_q;
    logic              fwd_ok;

    // After a halt is accepted, no further beat enters until reset.
    assign ex_ready = buf_in_ready && !halted_q;
    assign accept   = ex_valid && ex_ready;
    assign taken    = accept && ctrl[CTRL_BRANCH] && (alu_zeroFlag ^ ctrl[CTRL_BRANCHNE]);

    always_comb begin
        in_entry       = '0;
        in_entry.addr  = alu_Result;
        in_entry.wdata = rtData;
        in_entry.rd    = rdAddr;
        in_entry.ctrl  = to_mem_ctrl(ctrl, rdAddr == '0);
    end

    exmem_skid_buf #(
        .entry_t (entry_t)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (ex_valid && !halted_q),
        .in_ready  (buf_in_ready),
        .in_data   (in_entry),
        .out_valid (head_valid),
        .out_ready (mem_ready),
        .out_data  (head)
    );

    assign mem_valid = head_valid;
    assign mem_addr  = head.addr;
    assign mem_wdata = head.wdata;
    assign mem_rd    = head.rd;
    assign mem_ctrl  = head.ctrl;

    // Redirect is resolved at accept time, regardless of what MEM is doing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_q  <= 1'b0;
            pc_target_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            redirect_q <= taken;
            if (taken) begin
                pc_target_q <= branchTarget;
            end
            if (accept && ctrl[CTRL_HALT]) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign pcRedirect = redirect_q;
    assign pcTarget   = pc_target_q;

    // Loads are excluded: their value is not known until MEM completes.
    assign fwd_ok   = head_valid && head.ctrl[MCTRL_REGWRITE] && !head.ctrl[MCTRL_MEMREAD]
                      && (head.rd != '0);
    assign fwdValid = fwd_ok;
    assign fwdAddr  = fwd_ok ? head.rd : '0;
    assign fwdData  = fwd_ok ? head.addr : '0;

`ifdef EX_MEM_STATS_EN
    logic [31:0] stat_acc_q;
    logic [31:0] stat_stall_q;
    logic [31:0] stat_redir_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_acc_q   <= '0;
            stat_stall_q <= '0;
            stat_redir_q <= '0;
        end else begin
            if (accept) begin
                stat_acc_q <= stat_acc_q + 32'd1;
            end
            if (head_valid && !mem_ready) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
            if (redirect_q) begin
                stat_redir_q <= stat_redir_q + 32'd1;
            end
        end
    end

    assign statAccepted    = stat_acc_q;
    assign statStallCycles = stat_stall_q;
    assign statRedirects   = stat_redir_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: single-beat vector table plus stall, reset,
// halt and (with EX_MEM_STATS_EN) counter sequences.
`timescale 1ns/1ps
module tb_ex_mem_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_Result;
    logic        alu_zeroFlag;
    logic [31:0] rtData;
    logic [4:0]  rdAddr;
    logic [31:0] branchTarget;
    logic [6:0]  ctrl;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_rd;
    logic [4:0]  mem_ctrl;
    logic        pcRedirect;
    logic [31:0] pcTarget;
    logic        fwdValid;
    logic [4:0]  fwdAddr;
    logic [31:0] fwdData;
`ifdef EX_MEM_STATS_EN
    logic [31:0] statAccepted;
    logic [31:0] statStallCycles;
    logic [31:0] statRedirects;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ex_mem_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .alu_Result   (alu_Result),
        .alu_zeroFlag (alu_zeroFlag),
        .rtData       (rtData),
        .rdAddr       (rdAddr),
        .branchTarget (branchTarget),
        .ctrl         (ctrl),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rd       (mem_rd),
        .mem_ctrl     (mem_ctrl),
        .pcRedirect   (pcRedirect),
        .pcTarget     (pcTarget),
        .fwdValid     (fwdValid),
        .fwdAddr      (fwdAddr),
        .fwdData      (fwdData)
`ifdef EX_MEM_STATS_EN
        ,
        .statAccepted    (statAccepted),
        .statStallCycles (statStallCycles),
        .statRedirects   (statRedirects)
`endif
    );

    always #5 clk = ~clk;

    // Records every MEM handshake, sampled on the falling edge.
    logic        mon_en = 1'b0;
    logic [31:0] mon_q[$];
    always @(negedge clk) begin
        if (mon_en && mem_valid && mem_ready) mon_q.push_back(mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [31:0] res, input logic [4:0] rd, input logic [6:0] c,
                        input logic z = 1'b0, input logic [31:0] tgt = 32'h0);
        ex_valid     = 1'b1;
        alu_Result   = res;
        rtData       = 32'h0;
        rdAddr       = rd;
        ctrl         = c;
        alu_zeroFlag = z;
        branchTarget = tgt;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic        zero;
        logic [31:0] rt;
        logic [4:0]  rd;
        logic [31:0] tgt;
        logic [6:0]  ctl;
        logic        e_mv;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [4:0]  e_rd;
        logic [4:0]  e_mctrl;
        logic        e_redir;
        logic [31:0] e_tgt;
        logic        e_fv;
        logic [4:0]  e_fa;
        logic [31:0] e_fd;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        // ctl = {memRead, memWrite, regWrite, memToReg, branch, branchNe, halt}
        // e_mctrl = {memRead, memWrite, regWrite, memToReg, halt}
        vecs[0] = '{1'b1, 32'h7, 1'b0, 32'h0, 5'd5, 32'h0, 7'b0010000,
                    1'b1, 32'h7, 32'h0, 5'd5, 5'b00100, 1'b0, 32'h0, 1'b1, 5'd5, 32'h7};
        vecs[1] = '{1'b1, 32'h100, 1'b0, 32'h0, 5'd5, 32'h0, 7'b1011000,
                    1'b1, 32'h100, 32'h0, 5'd5, 5'b10110, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0};
        vecs[2] = '{1'b1, 32'h55, 1'b0, 32'h0, 5'd0, 32'h0, 7'b0010000,
                    1'b1, 32'h55, 32'h0, 5'd0, 5'b00000, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0};
        vecs[3] = '{1'b1, 32'h20, 1'b0, 32'hdead, 5'd3, 32'h0, 7'b0100000,
                    1'b1, 32'h20, 32'hdead, 5'd3, 5'b01000, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0};
        vecs[4] = '{1'b1, 32'h0, 1'b1, 32'h0, 5'd7, 32'h40, 7'b0010100,
                    1'b1, 32'h0, 32'h0, 5'd7, 5'b00000, 1'b1, 32'h40, 1'b0, 5'd0, 32'h0};
        vecs[5] = '{1'b1, 32'h0, 1'b1, 32'h0, 5'd0, 32'h80, 7'b0000110,
                    1'b1, 32'h0, 32'h0, 5'd0, 5'b00000, 1'b0, 32'h40, 1'b0, 5'd0, 32'h0};
        vecs[6] = '{1'b1, 32'h4, 1'b0, 32'h0, 5'd0, 32'h90, 7'b0000110,
                    1'b1, 32'h4, 32'h0, 5'd0, 5'b00000, 1'b1, 32'h90, 1'b0, 5'd0, 32'h0};
        vecs[7] = '{1'b1, 32'h4, 1'b0, 32'h0, 5'd0, 32'ha0, 7'b0000100,
                    1'b1, 32'h4, 32'h0, 5'd0, 5'b00000, 1'b0, 32'h90, 1'b0, 5'd0, 32'h0};
        vecs[8] = '{1'b1, 32'h1234, 1'b1, 32'h5678, 5'd9, 32'h0, 7'b0010000,
                    1'b1, 32'h1234, 32'h5678, 5'd9, 5'b00100, 1'b0, 32'h90, 1'b1, 5'd9,
                    32'h1234};
        vecs[9] = '{1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0, 7'b0,
                    1'b0, 32'h0, 32'h0, 5'd0, 5'b00000, 1'b0, 32'h90, 1'b0, 5'd0, 32'h0};

        rst_n     = 1'b0;
        mem_ready = 1'b1;
        beat(32'h10, 5'd1, 7'b0010000);

        // Reset held with a beat offered: nothing gets in.
        repeat (3) tick();
        chk("rst mem_valid", mem_valid, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst pcRedirect", pcRedirect, 0);
        chk("rst pcTarget", pcTarget, 0);
        chk("rst fwdValid", fwdValid, 0);
        rst_n = 1'b1;
        chk("post-rst ex_ready", ex_ready, 1);
        tick();
        ex_valid = 1'b0;
        chk("first beat valid", mem_valid, 1);
        chk("first beat addr", mem_addr, 32'h10);
        tick();

        for (int i = 0; i < NV; i++) begin
            ex_valid     = vecs[i].v;
            alu_Result   = vecs[i].res;
            alu_zeroFlag = vecs[i].zero;
            rtData       = vecs[i].rt;
            rdAddr       = vecs[i].rd;
            branchTarget = vecs[i].tgt;
            ctrl         = vecs[i].ctl;
            tick();
            chk($sformatf("v%0d mem_valid", i), mem_valid, vecs[i].e_mv);
            if (vecs[i].e_mv) begin
                chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
                chk($sformatf("v%0d mem_rd", i), mem_rd, vecs[i].e_rd);
                chk($sformatf("v%0d mem_ctrl", i), mem_ctrl, vecs[i].e_mctrl);
            end
            chk($sformatf("v%0d pcRedirect", i), pcRedirect, vecs[i].e_redir);
            chk($sformatf("v%0d pcTarget", i), pcTarget, vecs[i].e_tgt);
            chk($sformatf("v%0d fwdValid", i), fwdValid, vecs[i].e_fv);
            chk($sformatf("v%0d fwdAddr", i), fwdAddr, vecs[i].e_fa);
            chk($sformatf("v%0d fwdData", i), fwdData, vecs[i].e_fd);
            chk($sformatf("v%0d ex_ready", i), ex_ready, 1);
        end

        // Stall: A in head, B in skid, C held off, then drained in order.
        mon_q.delete();
        mon_en    = 1'b1;
        mem_ready = 1'b0;
        beat(32'h1, 5'd1, 7'b0010000);
        tick();
        beat(32'h2, 5'd2, 7'b0010000);
        tick();
        chk("stall ex_ready low", ex_ready, 0);
        beat(32'h3, 5'd3, 7'b0010000);
        tick();
        chk("stall head valid", mem_valid, 1);
        chk("stall head holds A", mem_addr, 32'h1);
        chk("stall C held off", ex_ready, 0);
        mem_ready = 1'b1;
        tick();
        chk("drain head B", mem_addr, 32'h2);
        chk("drain ex_ready up", ex_ready, 1);
        tick();
        ex_valid = 1'b0;
        chk("drain head C", mem_addr, 32'h3);
        tick();
        chk("drain empty", mem_valid, 0);
        mon_en = 1'b0;
        chk("order count", mon_q.size(), 3);
        if (mon_q.size() == 3) begin
            chk("order 0", mon_q[0], 32'h1);
            chk("order 1", mon_q[1], 32'h2);
            chk("order 2", mon_q[2], 32'h3);
        end

        // Reset with both entries full discards them.
        mem_ready = 1'b0;
        beat(32'ha, 5'd1, 7'b0010000);
        tick();
        beat(32'hb, 5'd2, 7'b0010000);
        tick();
        chk("full ex_ready", ex_ready, 0);
        ex_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        chk("midrst mem_valid", mem_valid, 0);
        chk("midrst ex_ready", ex_ready, 1);
        chk("midrst mem_addr", mem_addr, 0);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        mon_q.delete();
        mon_en = 1'b1;
        repeat (3) tick();
        mon_en = 1'b0;
        chk("midrst no stale beat", mon_q.size(), 0);

        // Halt locks the input until reset.
        beat(32'h99, 5'd0, 7'b0000001);
        tick();
        chk("halt mem_ctrl", mem_ctrl, 5'b00001);
        chk("halt ex_ready", ex_ready, 0);
        beat(32'h77, 5'd4, 7'b0010000);
        tick();
        chk("halt blocks beat", mem_valid, 0);
        tick();
        chk("halt ex_ready stays", ex_ready, 0);
        ex_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("halt cleared by reset", ex_ready, 1);

`ifdef EX_MEM_STATS_EN
        chk("stat acc rst", statAccepted, 0);
        chk("stat stall rst", statStallCycles, 0);
        chk("stat redir rst", statRedirects, 0);
        beat(32'h1, 5'd1, 7'b0010000);
        tick();
        beat(32'h0, 5'd0, 7'b0000100, 1'b1, 32'h200);
        tick();
        mem_ready = 1'b0;
        beat(32'h3, 5'd3, 7'b0010000);
        tick();
        ex_valid = 1'b0;
        tick();
        mem_ready = 1'b1;
        tick();
        beat(32'h4, 5'd4, 7'b0010000);
        tick();
        ex_valid = 1'b0;
        tick();
        chk("stat accepted", statAccepted, 4);
        chk("stat stalls", statStallCycles, 2);
        chk("stat redirects", statRedirects, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
